// File: rtl/gups_ctrl.sv
// gups_ctrl: run controller for the GUPS benchmark.
// Sits between N gups engines and the memory arbiter and gates each engine's
// req/rdy pair. A run starts on start_i, counts completed write handshakes and
// elapsed cycles, and ends at a target update count or on abort_i. In-flight
// transactions are drained before done_o is raised.
//
// Optional feature macro: GUPS_CTRL_PERCNT_EN (per-engine update counters).
//
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous reset, active-low
//   eng_req_i    req from engine i
//   eng_wr_i     wr from engine i
//   eng_rdy_o    rdy to engine i (combinational: arb_req & arb_rdy)
//   arb_req_o    gated req to arbiter port i (combinational)
//   arb_wr_o     wr to arbiter port i (= eng_wr_i)
//   arb_rdy_i    rdy from arbiter port i
//   start_i      1-cycle pulse: begin run
//   abort_i      1-cycle pulse: stop run early
//   target_i     update count that ends the run, sampled on start
//   busy_o       high in RUN or DRAIN
//   done_o       high in DONE
//   updates_o    completed write handshakes in this run
//   cycles_o     cycles spent in RUN plus DRAIN
//   upd_cnt_o    per-engine update counts (zero unless GUPS_CTRL_PERCNT_EN)
module gups_ctrl #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 48
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [N-1:0]       eng_req_i,
    input  logic [N-1:0]       eng_wr_i,
    output logic [N-1:0]       eng_rdy_o,
    output logic [N-1:0]       arb_req_o,
    output logic [N-1:0]       arb_wr_o,
    input  logic [N-1:0]       arb_rdy_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [CNT_W-1:0]   target_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   updates_o,
    output logic [CNT_W-1:0]   cycles_o,
    output logic [N*CNT_W-1:0] upd_cnt_o
);

    localparam int unsigned POP_W = $clog2(N + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  target_q, updates_q, cycles_q;
    logic [N-1:0]      inflight_q, inflight_d;
    logic              busy_q, done_q;

    logic [N-1:0]      arb_req_c;
    logic [N-1:0]      wr_hs_c;
    logic              clr_c;
    logic              count_en_c;
    logic              start_ok_c;
    logic [POP_W-1:0]  pop_c;
    logic [SUM_W-1:0]  upd_sum_c;
    logic [CNT_W-1:0]  upd_sat_c;
    logic [CNT_W-1:0]  cyc_sat_c;

    // abort wins over a simultaneous start
    assign start_ok_c = start_i & ~abort_i;

    // state register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_c) begin
                    state_d = (target_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i || (upd_sat_c >= target_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // leave once nothing will be outstanding after this cycle
                if (inflight_d == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // output / control decode
    always_comb begin
        arb_req_c  = '0;
        count_en_c = 1'b0;
        clr_c      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                clr_c = start_ok_c;
            end
            S_RUN: begin
                arb_req_c  = eng_req_i;
                count_en_c = 1'b1;
            end
            S_DRAIN: begin
                // only transactions already presented may finish
                arb_req_c  = eng_req_i & inflight_q;
                count_en_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign wr_hs_c    = arb_req_c & eng_wr_i & arb_rdy_i;
    assign inflight_d = (arb_req_c & ~arb_rdy_i) | (inflight_q & ~arb_req_c);

    // number of write completions this cycle
    always_comb begin
        pop_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pop_c = pop_c + POP_W'(wr_hs_c[i]);
        end
    end

    assign upd_sum_c = {1'b0, updates_q} + SUM_W'(pop_c);
    assign upd_sat_c = upd_sum_c[CNT_W] ? '1 : upd_sum_c[CNT_W-1:0];
    assign cyc_sat_c = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);

    // run counters and target latch
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            target_q  <= '0;
            updates_q <= '0;
            cycles_q  <= '0;
        end else if (clr_c) begin
            target_q  <= target_i;
            updates_q <= '0;
            cycles_q  <= '0;
        end else if (count_en_c) begin
            updates_q <= upd_sat_c;
            cycles_q  <= cyc_sat_c;
        end
    end

    // outstanding (presented but not accepted) transactions
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // status flags
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q <= (state_d == S_DONE);
        end
    end

`ifdef GUPS_CTRL_PERCNT_EN
    // per-engine write completion counters
    for (genvar g = 0; g < N; g++) begin : g_pcnt
        logic [CNT_W-1:0] pcnt_q;
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                pcnt_q <= '0;
            end else if (clr_c) begin
                pcnt_q <= '0;
            end else if (count_en_c && wr_hs_c[g] && (pcnt_q != '1)) begin
                pcnt_q <= pcnt_q + CNT_W'(1);
            end
        end
        assign upd_cnt_o[g*CNT_W +: CNT_W] = pcnt_q;
    end
`else
    assign upd_cnt_o = '0;
`endif

    assign arb_req_o = arb_req_c;
    assign arb_wr_o  = eng_wr_i;
    assign eng_rdy_o = arb_req_c & arb_rdy_i;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign updates_o = updates_q;
    assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_gups_ctrl.sv
// tb_gups_ctrl: self-checking bench for gups_ctrl with a run-level reference
// model and a narrow-counter instance for saturation.
module tb_gups_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 48;
    localparam longint unsigned MAXV = (64'd1 << CW) - 64'd1;
    localparam int M_HOLD = 0, M_ALT = 1, M_ONESHOT = 2, M_RND = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    eng_req = '0, eng_wr = '0, arb_rdy = '0;
    logic            start = 1'b0, abort = 1'b0;
    logic [CW-1:0]   target = '0;
    logic [3:0]      target_s = '0;
    logic [N-1:0]    eng_rdy_o, arb_req_o, arb_wr_o;
    logic            busy_o, done_o;
    logic [CW-1:0]   updates_o, cycles_o;
    logic [N*CW-1:0] upd_cnt_o;
    logic [N-1:0]    eng_rdy_s, arb_req_s, arb_wr_s;
    logic            busy_s, done_s;
    logic [3:0]      updates_s, cycles_s;
    logic [N*4-1:0]  upd_cnt_s;

    int n_checks = 0;
    int n_errors = 0;
    int eng_mode = M_HOLD;

    // reference model: run phase 0 idle, 1 run, 2 drain, 3 done
    int              m_mode;
    logic [CW-1:0]   m_upd, m_cyc, m_tgt;
    logic [N-1:0]    m_pend;
    logic [CW-1:0]   m_pc [N];

    gups_ctrl #(.N(N), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(rst), .eng_req_i(eng_req), .eng_wr_i(eng_wr),
        .eng_rdy_o(eng_rdy_o), .arb_req_o(arb_req_o), .arb_wr_o(arb_wr_o),
        .arb_rdy_i(arb_rdy), .start_i(start), .abort_i(abort), .target_i(target),
        .busy_o(busy_o), .done_o(done_o), .updates_o(updates_o),
        .cycles_o(cycles_o), .upd_cnt_o(upd_cnt_o)
    );

    gups_ctrl #(.N(N), .CNT_W(4)) dut_s (
        .clk_i(clk), .reset_i(rst), .eng_req_i(eng_req), .eng_wr_i(eng_wr),
        .eng_rdy_o(eng_rdy_s), .arb_req_o(arb_req_s), .arb_wr_o(arb_wr_s),
        .arb_rdy_i(arb_rdy), .start_i(start), .abort_i(abort), .target_i(target_s),
        .busy_o(busy_s), .done_o(done_s), .updates_o(updates_s),
        .cycles_o(cycles_s), .upd_cnt_o(upd_cnt_s)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input int unsigned b);
        longint unsigned s;
        s = 64'(a) + 64'(b);
        if (s > MAXV) s = MAXV;
        return CW'(s);
    endfunction

    function automatic logic [N-1:0] m_gate();
        case (m_mode)
            1:       return eng_req;
            2:       return eng_req & m_pend;
            default: return '0;
        endcase
    endfunction

    function automatic logic [N*CW-1:0] m_pc_flat();
        logic [N*CW-1:0] f;
        for (int i = 0; i < N; i++) f[i*CW +: CW] = m_pc[i];
        return f;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_upd = '0; m_cyc = '0; m_tgt = '0; m_pend = '0;
        for (int i = 0; i < N; i++) m_pc[i] = '0;
    endfunction

    function automatic void model_update();
        logic [N-1:0] g, hs;
        g  = m_gate();
        hs = g & arb_rdy;
        for (int i = 0; i < N; i++) if (g[i]) m_pend[i] = !arb_rdy[i];
        if (m_mode == 0 || m_mode == 3) begin
            if (start && !abort) begin
                m_tgt = target; m_upd = '0; m_cyc = '0;
                for (int i = 0; i < N; i++) m_pc[i] = '0;
                m_mode = (target == '0) ? 3 : 1;
            end
        end else begin
            m_cyc = sat_add(m_cyc, 1);
            m_upd = sat_add(m_upd, $countones(hs & eng_wr));
            for (int i = 0; i < N; i++) m_pc[i] = sat_add(m_pc[i], 32'(hs[i] & eng_wr[i]));
            if (m_mode == 1) begin
                if (abort || (m_upd >= m_tgt)) m_mode = 2;
            end else if (m_pend == '0) begin
                m_mode = 3;
            end
        end
    endfunction

    // one clock: advance model, clear pulses, let engines react to handshakes
    task automatic tick();
        logic [N-1:0] hs;
        hs = m_gate() & arb_rdy;
        @(posedge clk);
        model_update();
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < N; i++) begin
            case (eng_mode)
                M_ALT:     if (hs[i]) eng_wr[i] = ~eng_wr[i];
                M_ONESHOT: if (hs[i]) eng_req[i] = 1'b0;
                M_RND: if (hs[i] || !eng_req[i]) begin
                    eng_req[i] = ($urandom_range(3) != 0);
                    eng_wr[i]  = 1'($urandom_range(1));
                end
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        eng_req = '1; eng_wr = '0; arb_rdy = '1; eng_mode = M_HOLD;
        #1 rst = 1'b0;
        #1;
        model_reset();
        n_checks++; if (arb_req_o !== '0) begin n_errors++; $display("FAIL reset_arb_req: got %h expected 0", arb_req_o); end
        n_checks++; if (eng_rdy_o !== '0) begin n_errors++; $display("FAIL reset_eng_rdy: got %h expected 0", eng_rdy_o); end
        n_checks++; if ({busy_o, done_o} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b expected 00", {busy_o, done_o}); end
        n_checks++; if ({updates_o, cycles_o} !== '0) begin n_errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", updates_o, cycles_o); end
        n_checks++; if (upd_cnt_o !== '0) begin n_errors++; $display("FAIL reset_upd_cnt: got %h expected 0", upd_cnt_o); end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_basic();
        eng_mode = M_ALT; eng_req = '1; eng_wr = '0; arb_rdy = '1; target = 48'd8; start = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if ({busy_o, arb_req_o} !== {1'b1, 4'hF}) begin n_errors++; $display("FAIL basic_run_entry: got busy=%b req=%h expected 1/f", busy_o, arb_req_o); end
        for (int c = 0; c < 4; c++) tick();
        @(negedge clk);
        n_checks++; if ({busy_o, done_o, arb_req_o} !== {1'b1, 1'b0, 4'h0}) begin n_errors++; $display("FAIL basic_drain: got busy=%b done=%b req=%h expected 1/0/0", busy_o, done_o, arb_req_o); end
        tick();
        @(negedge clk);
        n_checks++; if ({busy_o, done_o} !== 2'b01) begin n_errors++; $display("FAIL basic_done: got %b expected 01", {busy_o, done_o}); end
        n_checks++; if ({updates_o, cycles_o} !== {48'd8, 48'd5}) begin n_errors++; $display("FAIL basic_counts: got %0d/%0d expected 8/5", updates_o, cycles_o); end
    endtask

    task automatic test_drain();
        eng_mode = M_ONESHOT; eng_req = 4'b0101; eng_wr = 4'b0001; arb_rdy = 4'b1011;
        target = 48'd1; start = 1'b1;
        tick();
        tick();
        eng_req[0] = 1'b1; eng_wr[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if ({busy_o, done_o} !== 2'b10) begin n_errors++; $display("FAIL drain_wait_flags: got %b expected 10", {busy_o, done_o}); end
            n_checks++; if (arb_req_o !== 4'b0100) begin n_errors++; $display("FAIL drain_gating: got %h expected 4", arb_req_o); end
            tick();
        end
        arb_rdy[2] = 1'b1;
        @(negedge clk);
        n_checks++; if ({done_o, eng_rdy_o} !== {1'b0, 4'b0100}) begin n_errors++; $display("FAIL drain_release: got done=%b rdy=%h expected 0/4", done_o, eng_rdy_o); end
        tick();
        @(negedge clk);
        n_checks++; if ({busy_o, done_o} !== 2'b01) begin n_errors++; $display("FAIL drain_done: got %b expected 01", {busy_o, done_o}); end
        n_checks++; if ({updates_o, cycles_o} !== {48'd1, 48'd7}) begin n_errors++; $display("FAIL drain_counts: got %0d/%0d expected 1/7", updates_o, cycles_o); end
    endtask

    task automatic test_abort();
        logic [N-1:0] prev;
        bit fin;
        do_reset();
        eng_mode = M_RND; eng_req = '1; eng_wr = 4'b0101; arb_rdy = '1; target = 48'd1000; start = 1'b1;
        tick();
        for (int c = 1; c < 10; c++) begin arb_rdy = 4'($urandom); tick(); end
        abort = 1'b1; arb_rdy = 4'($urandom);
        @(negedge clk);
        prev = arb_req_o;
        tick();
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            arb_rdy = 4'($urandom);
            @(negedge clk);
            n_checks++; if ((arb_req_o & ~prev) !== '0) begin n_errors++; $display("FAIL abort_new_req: got rising %h expected 0", arb_req_o & ~prev); end
            n_checks++; if (arb_req_o !== m_gate()) begin n_errors++; $display("FAIL abort_gate: got %h expected %h", arb_req_o, m_gate()); end
            prev = arb_req_o;
            tick();
            fin = (m_mode == 3);
        end
        n_checks++; if (!fin) begin n_errors++; $display("FAIL abort_timeout: got no done expected done within 200 cycles"); end
        @(negedge clk);
        n_checks++; if ({busy_o, done_o} !== 2'b01) begin n_errors++; $display("FAIL abort_done: got %b expected 01", {busy_o, done_o}); end
        n_checks++; if (!(updates_o < 48'd1000)) begin n_errors++; $display("FAIL abort_updates_lt: got %0d expected <1000", updates_o); end
        n_checks++; if ({updates_o, cycles_o} !== {m_upd, m_cyc}) begin n_errors++; $display("FAIL abort_counts: got %0d/%0d expected %0d/%0d", updates_o, cycles_o, m_upd, m_cyc); end
        tick();
    endtask

    task automatic test_edges();
        do_reset();
        eng_mode = M_HOLD; eng_req = '0; eng_wr = '0; arb_rdy = '1;
        target = 48'd5; start = 1'b1; abort = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if ({busy_o, done_o} !== 2'b00) begin n_errors++; $display("FAIL edge_start_abort: got %b expected 00", {busy_o, done_o}); end
        target = 48'd0; start = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if ({busy_o, done_o, updates_o, cycles_o} !== {2'b01, 96'd0}) begin n_errors++; $display("FAIL edge_target0: got busy=%b done=%b %0d/%0d expected 0/1 0/0", busy_o, done_o, updates_o, cycles_o); end
        eng_mode = M_ALT; eng_req = '1; eng_wr = '0; target = 48'd1000; start = 1'b1;
        tick();
        tick(); tick();
        start = 1'b1; target = 48'd2;
        tick(); tick();
        @(negedge clk);
        n_checks++; if ({busy_o, updates_o, cycles_o} !== {1'b1, 48'd8, 48'd4}) begin n_errors++; $display("FAIL edge_start_in_run: got busy=%b %0d/%0d expected 1 8/4", busy_o, updates_o, cycles_o); end
        abort = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if ({busy_o, done_o, updates_o, cycles_o} !== {2'b01, 48'd8, 48'd6}) begin n_errors++; $display("FAIL edge_abort_done: got busy=%b done=%b %0d/%0d expected 0/1 8/6", busy_o, done_o, updates_o, cycles_o); end
        abort = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if ({done_o, updates_o, cycles_o} !== {1'b1, 48'd8, 48'd6}) begin n_errors++; $display("FAIL edge_abort_in_done: got done=%b %0d/%0d expected 1 8/6", done_o, updates_o, cycles_o); end
        tick();
    endtask

    task automatic test_reset_midrun();
        eng_mode = M_HOLD; eng_req = '1; eng_wr = '1; arb_rdy = 4'b0011; target = 48'd1000; start = 1'b1;
        tick(); tick(); tick();
        #3 rst = 1'b0;
        #1;
        model_reset();
        n_checks++; if ({arb_req_o, eng_rdy_o} !== 8'h00) begin n_errors++; $display("FAIL midrun_reset_gating: got req=%h rdy=%h expected 0/0", arb_req_o, eng_rdy_o); end
        n_checks++; if ({busy_o, done_o, updates_o, cycles_o} !== '0) begin n_errors++; $display("FAIL midrun_reset_state: got busy=%b done=%b %0d/%0d expected all 0", busy_o, done_o, updates_o, cycles_o); end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_percnt();
        logic [N*CW-1:0] exp_pc;
        do_reset();
        eng_mode = M_HOLD; eng_req = 4'b0010; eng_wr = 4'b0010; arb_rdy = '1; target = 48'd5; start = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) tick();
        @(negedge clk);
`ifdef GUPS_CTRL_PERCNT_EN
        exp_pc = {48'd0, 48'd0, 48'd5, 48'd0};
`else
        exp_pc = '0;
`endif
        n_checks++; if ({done_o, updates_o, cycles_o} !== {1'b1, 48'd5, 48'd6}) begin n_errors++; $display("FAIL percnt_run: got done=%b %0d/%0d expected 1 5/6", done_o, updates_o, cycles_o); end
        n_checks++; if (upd_cnt_o !== exp_pc) begin n_errors++; $display("FAIL percnt_values: got %h expected %h", upd_cnt_o, exp_pc); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        eng_mode = M_HOLD; eng_req = 4'b0001; eng_wr = '0; arb_rdy = '1;
        target = 48'd1000; target_s = 4'd15; start = 1'b1;
        tick();
        for (int c = 0; c < 20; c++) tick();
        @(negedge clk);
        n_checks++; if ({busy_s, updates_s, cycles_s} !== {1'b1, 4'd0, 4'd15}) begin n_errors++; $display("FAIL sat_cycles: got busy=%b %0d/%0d expected 1 0/15", busy_s, updates_s, cycles_s); end
        abort = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_checks++; if ({done_s, cycles_s} !== {1'b1, 4'd15}) begin n_errors++; $display("FAIL sat_cycles_hold: got done=%b cyc=%0d expected 1/15", done_s, cycles_s); end
        eng_req = '1; eng_wr = '1; start = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) tick();
        @(negedge clk);
        n_checks++; if ({done_s, updates_s, cycles_s} !== {1'b1, 4'd15, 4'd5}) begin n_errors++; $display("FAIL sat_updates: got done=%b %0d/%0d expected 1 15/5", done_s, updates_s, cycles_s); end
        tick();
    endtask

    task automatic test_random();
        bit fin;
        do_reset();
        eng_mode = M_RND; eng_req = '0; eng_wr = '0;
        for (int r = 0; r < 8; r++) begin
            target = 48'($urandom_range(40, 1)); start = 1'b1; arb_rdy = 4'($urandom);
            fin = 1'b0;
            for (int c = 0; c < 400 && !fin; c++) begin
                if (c > 0) begin
                    arb_rdy = 4'($urandom);
                    if ($urandom_range(59) == 0) abort = 1'b1;
                    if ($urandom_range(29) == 0) begin start = 1'b1; target = 48'($urandom_range(40)); end
                end
                @(negedge clk);
                n_checks++; if ({arb_req_o, eng_rdy_o, arb_wr_o} !== {m_gate(), m_gate() & arb_rdy, eng_wr}) begin
                    n_errors++; $display("FAIL rand_ports: got req=%h rdy=%h wr=%h expected %h/%h/%h", arb_req_o, eng_rdy_o, arb_wr_o, m_gate(), m_gate() & arb_rdy, eng_wr);
                end
                n_checks++; if ({busy_o, done_o, updates_o, cycles_o} !== {(m_mode == 1 || m_mode == 2), (m_mode == 3), m_upd, m_cyc}) begin
                    n_errors++; $display("FAIL rand_state: got busy=%b done=%b %0d/%0d expected mode %0d %0d/%0d", busy_o, done_o, updates_o, cycles_o, m_mode, m_upd, m_cyc);
                end
                tick();
                fin = (m_mode == 3);
            end
            n_checks++; if (!fin) begin n_errors++; $display("FAIL rand_timeout: got no done expected done within 400 cycles (run %0d)", r); end
            @(negedge clk);
            n_checks++; if ({done_o, updates_o, cycles_o} !== {1'b1, m_upd, m_cyc}) begin n_errors++; $display("FAIL rand_final: got done=%b %0d/%0d expected 1 %0d/%0d", done_o, updates_o, cycles_o, m_upd, m_cyc); end
`ifdef GUPS_CTRL_PERCNT_EN
            n_checks++; if (upd_cnt_o !== m_pc_flat()) begin n_errors++; $display("FAIL rand_percnt: got %h expected %h", upd_cnt_o, m_pc_flat()); end
`else
            n_checks++; if (upd_cnt_o !== '0) begin n_errors++; $display("FAIL rand_percnt_off: got %h expected 0", upd_cnt_o); end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain();
        test_abort();
        test_edges();
        test_reset_midrun();
        test_percnt();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
